usb_txn_ctrl: RTL and testbench
===============================

# usb_txn_ctrl

Transaction sequencer for the host-side USB serial datapath. It accepts a read (IN) or write (OUT) request and issues the start strobes to the packet sender and to the receive_data / receive_acknak receiver FSMs. It owns bus direction and retries failed transactions up to a fixed attempt limit. It sits between the top-level host FSM and the per-packet send/receive machinery.

## Interface
- MAX_ATTEMPTS, 8: total attempts per transaction before fail; must be at least 1.
- clk  in  1  clock
- rst_l  in  1  reset; asynchronous, active-low
- start_read  in  1  request IN transaction; sampled in IDLE only
- start_write  in  1  request OUT transaction; sampled in IDLE only
- send_token  out  1  pulse: sender transmits token with token_pid
- token_pid  out  4  OUT=4'b0001, IN=4'b1001; held while busy
- send_data  out  1  pulse: sender transmits DATA0 (data_pid=4'b0011)
- data_pid  out  4  constant 4'b0011
- send_hand  out  1  pulse: sender transmits handshake with hand_pid
- hand_pid  out  4  ACK=4'b0010, NAK=4'b1010; valid while send_hand high and until send_done
- send_done  in  1  pulse: sender finished the current packet, EOP included
- r_data_start  out  1  pulse: start receive_data FSM
- r_data_success, r_data_fail  in  1  pulses from receive_data
- receive_hand  out  1  pulse: start receive_acknak FSM
- ack, nak, r_acknak_fail  in  1  pulses from receive_acknak
- drive_en  out  1  1 = host drives DP/DM
- busy  out  1  high in every state except IDLE
- done  out  1  pulse at transaction end
- success  out  1  qualifies done: 1 = success, 0 = failure
- attempts  out  $clog2(MAX_ATTEMPTS+1)  attempts used by the current or last transaction

## Operation
- States: IDLE, TOKEN, DATA_OUT, WAIT_HS, WAIT_DATA, SEND_HS, FINISH.
- IDLE:
  - If start_read and start_write are both high, read wins and the write is dropped.
  - Either start latches direction, clears attempts to 1, and moves to TOKEN.
  - Starts seen while busy are ignored, not queued.
- TOKEN: send_done moves to DATA_OUT for a write or WAIT_DATA for a read.
- DATA_OUT: send_done moves to WAIT_HS.
- WAIT_HS: receive_hand is asserted on entry.
  - ack: success; go to FINISH.
  - nak or r_acknak_fail: retry.
- WAIT_DATA: r_data_start is asserted on entry.
  - r_data_success: hand_pid=ACK; go to SEND_HS.
  - r_data_fail: hand_pid=NAK; go to SEND_HS.
- SEND_HS: send_done goes to FINISH (success) if ACK was sent; otherwise retry.
- Retry:
  - If attempts == MAX_ATTEMPTS, go to FINISH with failure.
  - Otherwise increment attempts and go to TOKEN.
  - Direction is unchanged.
- FINISH: done=1 for exactly one cycle, then IDLE.
- Completion pulses that arrive in a state not waiting for them are ignored. This includes a stray ack during WAIT_DATA.
- No internal timeout: timeouts are reported by the receiver FSMs as fail pulses.

## Timing
- Reset values: every output is 0 except data_pid (4'b0011); attempts=0; state IDLE.
- Start accepted at edge k:
  - send_token is high during cycle k+1 only.
  - busy and drive_en rise at edge k.
- Strobes (send_token, send_data, send_hand, r_data_start, receive_hand) are registered and high exactly for the first cycle of their state. They are never held and never re-issued within one visit.
- An input completion pulse is accepted on any cycle of the owning state, including the strobe cycle. The transition happens at the next edge.
- drive_en is 1 in TOKEN, DATA_OUT and SEND_HS, and 0 elsewhere. It changes on the same edge as the state.
- success is valid only while done=1. It is 0 otherwise.
- attempts saturates at MAX_ATTEMPTS and holds its value after done until the next start.
- Reset mid-transaction: immediate return to IDLE with all outputs at reset values. No done pulse.

## Structure
- Shared package usb_pkg:
  - PID constants (PID_OUT, PID_IN, PID_DATA0, PID_ACK, PID_NAK).
  - The transaction-state enum.
  - Direction typedef (DIR_READ/DIR_WRITE).
- One sub-module, txn_attempt_ctr:
  - Inputs: clear-to-1, increment, parameterised limit.
  - Outputs: count and at_limit.
- The FSM and strobe generation live in usb_txn_ctrl.

## Test plan
- Write, clean: start_write; send_done after the token and after the data; ack → pulse order send_token, send_data, receive_hand; done=1 with success=1; attempts=1; token_pid=0001.
- Read, clean: start_read; send_done; r_data_success → send_hand with hand_pid=0010; after send_done, done with success=1; drive_en 1/0/1 across TOKEN/WAIT_DATA/SEND_HS.
- Write NAK ×3 then ack → 4 send_token pulses; done with success=1; attempts=4.
- Read r_data_fail 8 times with MAX_ATTEMPTS=8 → 8 NAK handshakes sent; done with success=0; attempts=8; no 9th token.
- Simultaneous start_read and start_write in IDLE → token_pid=1001. A start_write asserted while busy has no effect.
- rst_l low during DATA_OUT → all outputs 0 immediately with no done pulse; a subsequent start_write runs a clean transaction with attempts=1.

Source files
------------

// File: rtl/usb_pkg.sv
// Shared types and PID constants for the host-side USB datapath.
// Imported by the transaction sequencer and its attempt counter.
package usb_pkg;

    localparam logic [3:0] PID_OUT   = 4'b0001;
    localparam logic [3:0] PID_IN    = 4'b1001;
    localparam logic [3:0] PID_DATA0 = 4'b0011;
    localparam logic [3:0] PID_ACK   = 4'b0010;
    localparam logic [3:0] PID_NAK   = 4'b1010;

    typedef enum logic [2:0] {
        IDLE,
        TOKEN,
        DATA_OUT,
        WAIT_HS,
        WAIT_DATA,
        SEND_HS,
        FINISH
    } txn_state_t;

    typedef enum logic {
        DIR_READ,
        DIR_WRITE
    } txn_dir_t;

endpackage

// File: rtl/txn_attempt_ctr.sv
// Attempt counter: loads 1 on a new transaction, counts retries,
// saturates at LIMIT and holds its value between transactions.
module txn_attempt_ctr #(
    parameter int LIMIT = 8,
    parameter int W     = $clog2(LIMIT + 1)
) (
    input  logic         clk,
    input  logic         rst_l,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count,
    output logic         at_limit
);

    assign at_limit = (count == W'(LIMIT));

    // clear-to-1 wins over increment; increment stops at LIMIT
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            count <= '0;
        end else if (clr) begin
            count <= W'(1);
        end else if (inc && !at_limit) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/usb_txn_ctrl.sv
// IN/OUT transaction sequencer: issues sender/receiver start strobes,
// owns bus direction and retries up to MAX_ATTEMPTS attempts.
module usb_txn_ctrl
    import usb_pkg::*;
#(
    parameter int MAX_ATTEMPTS = 8
) (
    input  logic       clk,
    input  logic       rst_l,
    input  logic       start_read,
    input  logic       start_write,
    output logic       send_token,
    output logic [3:0] token_pid,
    output logic       send_data,
    output logic [3:0] data_pid,
    output logic       send_hand,
    output logic [3:0] hand_pid,
    input  logic       send_done,
    output logic       r_data_start,
    input  logic       r_data_success,
    input  logic       r_data_fail,
    output logic       receive_hand,
    input  logic       ack,
    input  logic       nak,
    input  logic       r_acknak_fail,
    output logic       drive_en,
    output logic       busy,
    output logic       done,
    output logic       success,
    output logic [$clog2(MAX_ATTEMPTS+1)-1:0] attempts
);

    localparam int AW = $clog2(MAX_ATTEMPTS + 1);

    txn_state_t state_q, state_d;
    txn_dir_t   dir_q, dir_d;
    logic [3:0] hs_q, hs_d;
    logic       ok_q, ok_d;
    logic       clr, inc, retry, at_limit;

    txn_attempt_ctr #(
        .LIMIT (MAX_ATTEMPTS),
        .W     (AW)
    ) u_ctr (
        .clk      (clk),
        .rst_l    (rst_l),
        .clr      (clr),
        .inc      (inc),
        .count    (attempts),
        .at_limit (at_limit)
    );

    // next-state, handshake choice and retry decision
    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        hs_d    = hs_q;
        ok_d    = ok_q;
        clr     = 1'b0;
        inc     = 1'b0;
        retry   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start_read || start_write) begin
                    dir_d   = start_read ? DIR_READ : DIR_WRITE;
                    clr     = 1'b1;
                    ok_d    = 1'b0;
                    state_d = TOKEN;
                end
            end
            TOKEN: begin
                if (send_done) begin
                    state_d = (dir_q == DIR_WRITE) ? DATA_OUT : WAIT_DATA;
                end
            end
            DATA_OUT: begin
                if (send_done) state_d = WAIT_HS;
            end
            WAIT_HS: begin
                if (ack) begin
                    ok_d    = 1'b1;
                    state_d = FINISH;
                end else if (nak || r_acknak_fail) begin
                    retry = 1'b1;
                end
            end
            WAIT_DATA: begin
                if (r_data_success) begin
                    hs_d    = PID_ACK;
                    state_d = SEND_HS;
                end else if (r_data_fail) begin
                    hs_d    = PID_NAK;
                    state_d = SEND_HS;
                end
            end
            SEND_HS: begin
                if (send_done) begin
                    if (hs_q == PID_ACK) begin
                        ok_d    = 1'b1;
                        state_d = FINISH;
                    end else begin
                        retry = 1'b1;
                    end
                end
            end
            FINISH: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (retry) begin
            if (at_limit) begin
                ok_d    = 1'b0;
                state_d = FINISH;
            end else begin
                inc     = 1'b1;
                state_d = TOKEN;
            end
        end
    end

    // state, direction, handshake pid and strobes on state entry
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state_q      <= IDLE;
            dir_q        <= DIR_READ;
            hs_q         <= 4'b0000;
            ok_q         <= 1'b0;
            send_token   <= 1'b0;
            send_data    <= 1'b0;
            send_hand    <= 1'b0;
            r_data_start <= 1'b0;
            receive_hand <= 1'b0;
        end else begin
            state_q      <= state_d;
            dir_q        <= dir_d;
            hs_q         <= hs_d;
            ok_q         <= ok_d;
            send_token   <= (state_d != state_q) && (state_d == TOKEN);
            send_data    <= (state_d != state_q) && (state_d == DATA_OUT);
            send_hand    <= (state_d != state_q) && (state_d == SEND_HS);
            r_data_start <= (state_d != state_q) && (state_d == WAIT_DATA);
            receive_hand <= (state_d != state_q) && (state_d == WAIT_HS);
        end
    end

    assign busy      = (state_q != IDLE);
    assign done      = (state_q == FINISH);
    assign success   = done && ok_q;
    assign drive_en  = (state_q == TOKEN) || (state_q == DATA_OUT) ||
                       (state_q == SEND_HS);
    assign data_pid  = PID_DATA0;
    assign hand_pid  = (state_q == SEND_HS) ? hs_q : 4'b0000;
    assign token_pid = !busy ? 4'b0000 :
                       (dir_q == DIR_WRITE) ? PID_OUT : PID_IN;

endmodule

// File: tb/tb_usb_txn_ctrl.sv
// Directed bench for usb_txn_ctrl: clean IN/OUT, retries, exhaustion,
// start priority and asynchronous reset mid-transaction.
module tb_usb_txn_ctrl;

    logic       clk = 1'b0;
    logic       rst_l = 1'b0;
    logic       start_read = 1'b0, start_write = 1'b0;
    logic       send_done = 1'b0;
    logic       r_data_success = 1'b0, r_data_fail = 1'b0;
    logic       ack = 1'b0, nak = 1'b0, r_acknak_fail = 1'b0;
    logic       send_token, send_data, send_hand;
    logic       r_data_start, receive_hand;
    logic [3:0] token_pid, data_pid, hand_pid;
    logic       drive_en, busy, done, success;
    logic [3:0] attempts;

    int compared = 0;
    int mismatched = 0;
    int tok_cnt = 0, hs_cnt = 0, done_cnt = 0;
    int t0, h0, d0;

    usb_txn_ctrl #(.MAX_ATTEMPTS(8)) dut (
        .clk            (clk),
        .rst_l          (rst_l),
        .start_read     (start_read),
        .start_write    (start_write),
        .send_token     (send_token),
        .token_pid      (token_pid),
        .send_data      (send_data),
        .data_pid       (data_pid),
        .send_hand      (send_hand),
        .hand_pid       (hand_pid),
        .send_done      (send_done),
        .r_data_start   (r_data_start),
        .r_data_success (r_data_success),
        .r_data_fail    (r_data_fail),
        .receive_hand   (receive_hand),
        .ack            (ack),
        .nak            (nak),
        .r_acknak_fail  (r_acknak_fail),
        .drive_en       (drive_en),
        .busy           (busy),
        .done           (done),
        .success        (success),
        .attempts       (attempts)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (send_token) tok_cnt <= tok_cnt + 1;
        if (send_hand) hs_cnt <= hs_cnt + 1;
        if (done) done_cnt <= done_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // 0 send_done 1 ack 2 nak 3 r_data_success 4 r_data_fail
    task automatic pulse(input int w);
        case (w)
            0: send_done = 1'b1;
            1: ack = 1'b1;
            2: nak = 1'b1;
            3: r_data_success = 1'b1;
            default: r_data_fail = 1'b1;
        endcase
        tick();
        send_done = 1'b0;
        ack = 1'b0;
        nak = 1'b0;
        r_data_success = 1'b0;
        r_data_fail = 1'b0;
    endtask

    initial begin
        tick();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_data_pid", 32'(data_pid), 32'h3);
        check("rst_attempts", 32'(attempts), 32'd0);
        check("rst_outs", 32'({send_token, send_data, send_hand,
              r_data_start, receive_hand, drive_en, done, success,
              token_pid, hand_pid}), 32'd0);
        rst_l = 1'b1;
        tick();

        // clean write
        start_write = 1'b1;
        tick();
        start_write = 1'b0;
        check("w_token", 32'(send_token), 32'd1);
        check("w_busy_drv", 32'({busy, drive_en}), 32'b11);
        check("w_tpid", 32'(token_pid), 32'h1);
        check("w_att", 32'(attempts), 32'd1);
        pulse(0);
        check("w_data", 32'({send_token, send_data}), 32'b01);
        pulse(0);
        check("w_rhand", 32'({send_data, receive_hand, drive_en}),
              32'b010);
        tick();
        check("w_rhand_once", 32'(receive_hand), 32'd0);
        pulse(1);
        check("w_done", 32'({done, success}), 32'b11);
        check("w_done_att", 32'(attempts), 32'd1);
        tick();
        check("w_idle", 32'({done, success, busy, drive_en}), 32'd0);
        check("w_att_hold", 32'(attempts), 32'd1);

        // clean read
        start_read = 1'b1;
        tick();
        start_read = 1'b0;
        check("r_token", 32'({send_token, drive_en}), 32'b11);
        check("r_tpid", 32'(token_pid), 32'h9);
        pulse(0);
        check("r_rds", 32'({r_data_start, drive_en}), 32'b10);
        pulse(3);
        check("r_hand", 32'({send_hand, drive_en}), 32'b11);
        check("r_hpid", 32'(hand_pid), 32'h2);
        tick();
        check("r_hand_hold", 32'({send_hand, hand_pid}), 32'h02);
        pulse(0);
        check("r_done", 32'({done, success}), 32'b11);
        tick();

        // write, NAK x3 then ACK
        t0 = tok_cnt;
        start_write = 1'b1;
        tick();
        start_write = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("n_tok%0d", i), 32'(send_token), 32'd1);
            pulse(0);
            pulse(0);
            check($sformatf("n_rh%0d", i), 32'(receive_hand), 32'd1);
            pulse(i < 3 ? 2 : 1);
        end
        check("n_done", 32'({done, success}), 32'b11);
        check("n_att", 32'(attempts), 32'd4);
        tick();
        check("n_tokcnt", 32'(tok_cnt - t0), 32'd4);

        // read, r_data_fail until exhaustion
        t0 = tok_cnt;
        h0 = hs_cnt;
        start_read = 1'b1;
        tick();
        start_read = 1'b0;
        for (int i = 0; i < 8; i++) begin
            pulse(0);
            pulse(4);
            check($sformatf("f_nak%0d", i), 32'({send_hand, hand_pid}),
                  32'h1a);
            pulse(0);
        end
        check("f_done", 32'({done, success}), 32'b10);
        check("f_att", 32'(attempts), 32'd8);
        tick();
        tick();
        tick();
        check("f_tokcnt", 32'(tok_cnt - t0), 32'd8);
        check("f_hscnt", 32'(hs_cnt - h0), 32'd8);
        check("f_idle", 32'({busy, success}), 32'd0);

        // simultaneous starts, then start_write while busy
        start_read = 1'b1;
        start_write = 1'b1;
        tick();
        start_read = 1'b0;
        start_write = 1'b0;
        check("s_tpid", 32'(token_pid), 32'h9);
        start_write = 1'b1;
        pulse(0);
        check("s_rds", 32'({r_data_start, send_data}), 32'b10);
        check("s_tpid2", 32'(token_pid), 32'h9);
        start_write = 1'b0;
        pulse(3);
        pulse(0);
        check("s_done", 32'({done, success}), 32'b11);
        t0 = tok_cnt;
        tick();
        tick();
        tick();
        check("s_no_queue", 32'({busy, 28'(tok_cnt - t0)}), 32'd0);

        // reset during DATA_OUT
        start_write = 1'b1;
        tick();
        start_write = 1'b0;
        pulse(0);
        check("x_dataout", 32'(send_data), 32'd1);
        d0 = done_cnt;
        #2;
        rst_l = 1'b0;
        #1;
        check("x_outs", 32'({send_token, send_data, send_hand,
              r_data_start, receive_hand, drive_en, busy, done, success,
              token_pid, hand_pid}), 32'd0);
        check("x_att", 32'(attempts), 32'd0);
        check("x_dpid", 32'(data_pid), 32'h3);
        tick();
        rst_l = 1'b1;
        tick();
        check("x_nodone", 32'(done_cnt - d0), 32'd0);
        start_write = 1'b1;
        tick();
        start_write = 1'b0;
        check("x2_tok", 32'({send_token, token_pid}), 32'h11);
        check("x2_att", 32'(attempts), 32'd1);
        pulse(0);
        pulse(0);
        pulse(1);
        check("x2_done", 32'({done, success, attempts}), 32'h31);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
